// File: rtl/lsu.sv
// lsu -- load/store unit between a pipeline request port and a word-wide
// data memory. Byte and halfword stores are done as read-modify-write.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we                1=store, 0=load
//   req_size              0=byte, 1=halfword, 2/3=word
//   req_signed            sign-extend sub-word loads
//   req_addr              byte address (ADDR_W+2 bits)
//   req_wdata             right-aligned store data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             load result (0 for stores)
//   rsp_err               misaligned-access flag
//   mem_read, mem_write   data-memory strobes
//   mem_addr              word address
//   mem_wdata, mem_rdata  memory data
//
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned requests
// complete with rsp_err=1 and no memory access; when undefined the address
// is forced aligned and the access is executed normally.
//
// state  | meaning
// IDLE   | ready for a request
// LOAD   | reading the word for a load
// RMW_RD | reading the word to merge a sub-word store into
// WRITE  | writing the (merged) word
// ERR    | misaligned request, reporting the error (trap build only)
module lsu #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE} state_t;
`endif

  state_t            state, state_nxt;
  logic              we_q, signed_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q, merge_q;

  logic [1:0]        size_n;
  logic [ADDR_W+1:0] addr_n;
  logic              accept;
  logic [31:0]       load_val, store_word;

  // Size 3 behaves as word; the stored address is always aligned to the size.
  assign size_n = (req_size == 2'd3) ? 2'd2 : req_size;
  always_comb begin
    addr_n = req_addr;
    if (size_n == 2'd1) addr_n[0]   = 1'b0;
    if (size_n == 2'd2) addr_n[1:0] = 2'b00;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal;
  assign misal = ((size_n == 2'd1) && req_addr[0]) ||
                 ((size_n == 2'd2) && (req_addr[1:0] != 2'b00));
`endif

  assign accept = (state == S_IDLE) && req_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (misal)               state_nxt = S_ERR;
          else
`endif
          if (!req_we)             state_nxt = S_LOAD;
          else if (size_n == 2'd2) state_nxt = S_WRITE;
          else                     state_nxt = S_RMW_RD;
        end
      end
      S_LOAD:   state_nxt = S_IDLE;
      S_RMW_RD: state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
      S_ERR:    state_nxt = S_IDLE;
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Lane extraction and extension of the word being read.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (addr_q[1:0])
      2'd0:    b = mem_rdata[7:0];
      2'd1:    b = mem_rdata[15:8];
      2'd2:    b = mem_rdata[23:16];
      default: b = mem_rdata[31:24];
    endcase
    h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd0:    load_val = {{24{signed_q & b[7]}}, b};
      2'd1:    load_val = {{16{signed_q & h[15]}}, h};
      default: load_val = mem_rdata;
    endcase
  end

  // Sub-word stores replace only the addressed lanes of the word read back.
  always_comb begin
    store_word = merge_q;
    if (size_q == 2'd0) begin
      case (addr_q[1:0])
        2'd0:    store_word[7:0]   = wdata_q[7:0];
        2'd1:    store_word[15:8]  = wdata_q[7:0];
        2'd2:    store_word[23:16] = wdata_q[7:0];
        default: store_word[31:24] = wdata_q[7:0];
      endcase
    end else if (size_q == 2'd1) begin
      if (addr_q[1]) store_word[31:16] = wdata_q[15:0];
      else           store_word[15:0]  = wdata_q[15:0];
    end else begin
      store_word = wdata_q;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign mem_read  = (state == S_LOAD) || (state == S_RMW_RD);
  assign mem_write = (state == S_WRITE);
  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = (state == S_WRITE) ? store_word : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      merge_q   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        size_q   <= size_n;
        addr_q   <= addr_n;
        wdata_q  <= req_wdata;
      end
      case (state)
        S_LOAD: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= load_val;
        end
        S_RMW_RD: merge_q   <= mem_rdata;
        S_WRITE:  rsp_valid <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        S_ERR:    rsp_valid <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err <= 1'b0;
    else        rsp_err <= (state == S_ERR);
  end
`else
  assign rsp_err = 1'b0;
`endif

  // we_q is kept for visibility of the accepted request type in debug.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width toward data memory; byte address width is ADDR_W+2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  pipeline presents a memory request.
REQ-005 req_ready  output  1  high only in IDLE; a request is accepted on a rising edge with req_valid&req_ready.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_size  input  2  0=byte, 1=halfword, 2=word; 3 is treated as word.
REQ-008 req_signed  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-009 req_addr  input  ADDR_W+2  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-012 rsp_rdata  output  32  load result, valid with rsp_valid; 0 for stores.
REQ-013 rsp_err  output  1  misaligned-access flag, valid with rsp_valid.
REQ-014 mem_read, mem_write  output  1 each  data-memory strobes; never both high.
REQ-015 mem_addr  output  ADDR_W  word address = req_addr[ADDR_W+1:2] of the accepted request.
REQ-016 mem_wdata  output  32  full-word write data.
REQ-017 mem_rdata  input  32  memory read data; stable before the rising edge ending any cycle with mem_read high.

Function
REQ-018 FSM states IDLE, LOAD, RMW_RD, WRITE, ERR; mem_* outputs decoded from state and registered request only, never from req_* inputs.
REQ-019 IDLE accept: load -> LOAD; word store -> WRITE; byte/halfword store -> RMW_RD; misaligned (macro enabled) -> ERR.
REQ-020 LOAD: mem_read=1; at cycle end capture mem_rdata, select lane by addr[1:0] (byte) or addr[1] (halfword), extend per req_signed, assert rsp_valid next cycle, return to IDLE.
REQ-021 RMW_RD: mem_read=1; at cycle end latch mem_rdata into merge register, go to WRITE.
REQ-022 WRITE: mem_write=1; mem_wdata = req_wdata for word stores, else merge register with addressed byte/halfword lanes replaced by req_wdata[7:0]/[15:0]; at cycle end pulse rsp_valid, return to IDLE.
REQ-023 Latency from accept edge to rsp_valid: load 2 cycles, word store 2 cycles, sub-word store 3 cycles; rsp_valid high the same cycle req_ready returns high, allowing back-to-back requests.
REQ-024 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-025 ERR: no memory strobe; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; return to IDLE.
REQ-026 req_valid low in IDLE: no state change, all strobes low.

Reset
REQ-027 rst_n low forces IDLE immediately: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-028 Reset during RMW_RD or WRITE aborts without any memory write; no rsp_valid is produced for the aborted request.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN defined: misaligned requests follow REQ-025.
REQ-030 Macro undefined: ERR state absent, rsp_err tied 0, misaligned addresses forced aligned (halfword clears addr[0], word clears addr[1:0]) and executed normally.

Verification
REQ-031 Word store 0xDEADBEEF @0x010, then word load @0x010 -> mem_write one cycle at mem_addr 0x04; load rsp_rdata=0xDEADBEEF, 2 cycles after accept.
REQ-032 Preload word 0x11223344 @0x020; byte store 0xAA @0x021 -> RMW_RD then WRITE, mem_wdata=0x1122AA44, rsp_valid 3 cycles after accept.
REQ-033 Word 0x8000FF7F @0x030: signed byte load @0x030 -> 0x0000007F; signed byte load @0x031 -> 0xFFFFFFFF; unsigned halfword load @0x032 -> 0x00008000; signed halfword load @0x032 -> 0xFFFF8000.
REQ-034 Macro on: halfword load @0x033 -> no strobes, rsp_err=1, rsp_rdata=0; macro off: same request reads word @0x030 and returns halfword lane 1 (addr forced to 0x032).
REQ-035 Assert rst_n low in RMW_RD of byte store @0x040 -> strobes drop immediately, memory word @0x040 unchanged, no rsp_valid.
REQ-036 req_valid held high for two loads -> second accepted on the rsp_valid cycle of the first; mem_read and mem_write never simultaneously high.
